count_seq_ctrl: RTL and testbench



---
 rtl/count_seq_pkg.sv | 28 ++
 rtl/count_core.sv | 46 ++++
 rtl/count_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_count_seq_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared types and defaults for the increment/hold count sequencer.
// Holds the FSM state encoding, the reset configuration and the config record.
package count_seq_pkg;

    localparam int SEQ_CW   = 4;
    localparam int SEQ_PW   = 3;
    localparam int DEF_INC  = 2;
    localparam int DEF_HOLD = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INC  = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [SEQ_PW-1:0] inc_len;
        logic [SEQ_PW-1:0] hold_len;
        logic [SEQ_CW-1:0] limit;
        logic              oneshot;
    } seq_cfg_t;

    // A zero INC length still advances the counter once per phase.
    function automatic logic [SEQ_PW-1:0] eff_inc_len(input logic [SEQ_PW-1:0] len);
        return (len == {SEQ_PW{1'b0}}) ? SEQ_PW'(1) : len;
    endfunction

endpackage

// File: rtl/count_core.sv
// CW-bit up-counter datapath: synchronous clear, count enable, registered wrap pulse.
module count_core #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] q,
    output logic          wrap
);

    logic [CW-1:0] q_d;
    logic [CW-1:0] q_q;
    logic          wrap_d;
    logic          wrap_q;

    // Next counter value and rollover detection.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (clr) begin
            q_d = {CW{1'b0}};
        end else if (en) begin
            q_d    = q_q + CW'(1);
            wrap_d = (q_q == {CW{1'b1}});
        end else begin
            q_d = q_q;
        end
    end

    // Counter and wrap registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= {CW{1'b0}};
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Increment/hold sequencer: alternates INC and HOLD phases of programmable length
// over a count_core datapath, with one-shot limit, continuous wrap and start/stop.
module count_seq_ctrl #(
    parameter int CW       = count_seq_pkg::SEQ_CW,
    parameter int PW       = count_seq_pkg::SEQ_PW,
    parameter int DEF_INC  = count_seq_pkg::DEF_INC,
    parameter int DEF_HOLD = count_seq_pkg::DEF_HOLD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [PW-1:0] cfg_inc_len,
    input  logic [PW-1:0] cfg_hold_len,
    input  logic [CW-1:0] cfg_limit,
    input  logic          cfg_oneshot,
    input  logic          start,
    input  logic          stop,
    output logic [CW-1:0] q,
    output logic          busy,
    output logic          inc_phase,
    output logic          done,
    output logic          wrap
);

    import count_seq_pkg::*;

    seq_state_e    state_d, state_q;
    logic [PW-1:0] pc_d, pc_q;
    seq_cfg_t      cfg_d, cfg_q;
    logic          busy_d, busy_q;
    logic          inc_phase_d, inc_phase_q;
    logic          done_d, done_q;
    logic          cfg_ready_d, cfg_ready_q;

    logic          cnt_clr;
    logic          cnt_en;
    logic          cfg_xfer;
    logic [CW-1:0] q_inc;
    logic [PW-1:0] inc_last;

    count_core #(.CW(CW)) u_core (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .q    (q),
        .wrap (wrap)
    );

    assign cfg_xfer = cfg_valid && cfg_ready_q;
    assign q_inc    = q + CW'(1);
    assign inc_last = eff_inc_len(cfg_q.inc_len) - PW'(1);

    // Phase sequencing, config capture and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cfg_d   = cfg_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_xfer) begin
                    cfg_d.inc_len  = cfg_inc_len;
                    cfg_d.hold_len = cfg_hold_len;
                    cfg_d.limit    = cfg_limit;
                    cfg_d.oneshot  = cfg_oneshot;
                end else begin
                    cfg_d = cfg_q;
                end
                if (start && !stop) begin
                    state_d = ST_INC;
                    pc_d    = {PW{1'b0}};
                    cnt_clr = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INC: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    pc_d    = {PW{1'b0}};
                end else begin
                    cnt_en = 1'b1;
                    // The limit is matched against the value this edge will load.
                    if (cfg_q.oneshot && (q_inc == cfg_q.limit)) begin
                        state_d = ST_IDLE;
                        pc_d    = {PW{1'b0}};
                        done_d  = 1'b1;
                    end else if (pc_q == inc_last) begin
                        pc_d    = {PW{1'b0}};
                        state_d = (cfg_q.hold_len != {PW{1'b0}}) ? ST_HOLD : ST_INC;
                    end else begin
                        pc_d = pc_q + PW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    pc_d    = {PW{1'b0}};
                end else if (pc_q == (cfg_q.hold_len - PW'(1))) begin
                    state_d = ST_INC;
                    pc_d    = {PW{1'b0}};
                end else begin
                    pc_d = pc_q + PW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = {PW{1'b0}};
            end
        endcase
        busy_d      = (state_d != ST_IDLE);
        inc_phase_d = (state_d == ST_INC);
        cfg_ready_d = (state_d == ST_IDLE);
    end

    // State, phase counter, configuration and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            pc_q             <= {PW{1'b0}};
            cfg_q.inc_len    <= PW'(DEF_INC);
            cfg_q.hold_len   <= PW'(DEF_HOLD);
            cfg_q.limit      <= {CW{1'b1}};
            cfg_q.oneshot    <= 1'b0;
            busy_q           <= 1'b0;
            inc_phase_q      <= 1'b0;
            done_q           <= 1'b0;
            cfg_ready_q      <= 1'b1;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            cfg_q            <= cfg_d;
            busy_q           <= busy_d;
            inc_phase_q      <= inc_phase_d;
            done_q           <= done_d;
            cfg_ready_q      <= cfg_ready_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign busy      = busy_q;
    assign inc_phase = inc_phase_q;
    assign done      = done_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl: expected outputs are queued as each cycle is
// driven and compared one cycle later, just after the clock edge.
module tb_count_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_inc_len;
    logic [2:0] cfg_hold_len;
    logic [3:0] cfg_limit;
    logic       cfg_oneshot;
    logic       start;
    logic       stop;
    logic [3:0] q;
    logic       busy;
    logic       inc_phase;
    logic       done;
    logic       wrap;

    logic [8:0] exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    count_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_inc_len  (cfg_inc_len),
        .cfg_hold_len (cfg_hold_len),
        .cfg_limit    (cfg_limit),
        .cfg_oneshot  (cfg_oneshot),
        .start        (start),
        .stop         (stop),
        .q            (q),
        .busy         (busy),
        .inc_phase    (inc_phase),
        .done         (done),
        .wrap         (wrap)
    );

    always #5 clk = ~clk;

    // Queue the expected post-edge outputs, clock once, then compare.
    task automatic cyc(input logic [3:0] eq, input logic eb, input logic ei,
                       input logic ed, input logic ew, input logic er, input string tag);
        logic [8:0] got;
        logic [8:0] want;
        exp_q.push_back({eq, eb, ei, ed, ew, er});
        @(posedge clk);
        #1;
        got  = {q, busy, inc_phase, done, wrap, cfg_ready};
        want = exp_q.pop_front();
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed q=%0d busy=%b inc=%b done=%b wrap=%b rdy=%b, expected q=%0d busy=%b inc=%b done=%b wrap=%b rdy=%b",
                   tag, got[8:5], got[4], got[3], got[2], got[1], got[0],
                   want[8:5], want[4], want[3], want[2], want[1], want[0]);
        end
    endtask

    initial begin
        logic [3:0] dq [12];
        logic       di [12];
        logic [3:0] rq [8];
        logic       ri [8];
        dq = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5, 4'd6, 4'd6};
        di = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        rq = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd4};
        ri = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_inc_len = 3'd0; cfg_hold_len = 3'd0; cfg_limit = 4'd0; cfg_oneshot = 1'b0;
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "reset0");
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "reset1");
        rst = 1'b0;

        // Default 2 inc / 2 hold run.
        start = 1'b1;
        cyc(dq[0], 1'b1, di[0], 1'b0, 1'b0, 1'b0, "def_start");
        start = 1'b0;
        for (int i = 1; i < 12; i++) cyc(dq[i], 1'b1, di[i], 1'b0, 1'b0, 1'b0, "def_run");
        stop = 1'b1;
        cyc(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "def_stop");
        stop = 1'b0;

        // One-shot, inc 3, no hold, limit 5.
        cfg_valid = 1'b1; cfg_inc_len = 3'd3; cfg_hold_len = 3'd0; cfg_limit = 4'd5; cfg_oneshot = 1'b1;
        cyc(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "os_cfg");
        cfg_valid = 1'b0; start = 1'b1;
        cyc(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "os_start");
        start = 1'b0;
        for (int i = 1; i <= 4; i++) cyc(4'(i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "os_run");
        cyc(4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "os_done");
        cyc(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "os_after0");
        cyc(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "os_after1");

        // Stop mid-INC at q=2, with start in the same cycle.
        start = 1'b1;
        cyc(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "stp_start");
        start = 1'b0;
        cyc(4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "stp_run1");
        cyc(4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "stp_run2");
        start = 1'b1; stop = 1'b1;
        cyc(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "stp_abort");
        cyc(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "stp_beats_start");
        start = 1'b0; stop = 1'b0;

        // Config and start together; continuous inc 1 / hold 1 run through a wrap.
        cfg_valid = 1'b1; cfg_inc_len = 3'd1; cfg_hold_len = 3'd1; cfg_limit = 4'hF; cfg_oneshot = 1'b0;
        start = 1'b1;
        cyc(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "cont_start");
        start = 1'b0; cfg_valid = 1'b0;
        cfg_inc_len = 3'd2; cfg_hold_len = 3'd3; cfg_limit = 4'hF; cfg_oneshot = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            cfg_valid = (i >= 5);
            cyc(4'((i + 1) / 2), 1'b1, (i % 2 == 0), 1'b0, (i == 31), 1'b0, "cont_run");
        end
        stop = 1'b1;
        cyc(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "cont_stop");
        stop = 1'b0;
        cyc(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "late_cfg");
        cfg_valid = 1'b0; start = 1'b1;
        cyc(rq[0], 1'b1, ri[0], 1'b0, 1'b0, 1'b0, "new_start");
        start = 1'b0;
        for (int i = 1; i < 8; i++) cyc(rq[i], 1'b1, ri[i], 1'b0, 1'b0, 1'b0, "new_run");

        // Reset mid-HOLD restores defaults.
        rst = 1'b1;
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst_mid");
        rst = 1'b0; start = 1'b1;
        cyc(dq[0], 1'b1, di[0], 1'b0, 1'b0, 1'b0, "post_rst_start");
        start = 1'b0;
        for (int i = 1; i < 7; i++) cyc(dq[i], 1'b1, di[i], 1'b0, 1'b0, 1'b0, "post_rst_run");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
